// File: rtl/aes_dec_core.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched by index
// from an external key-schedule store. Includes the shared InvSubBytes/InvMixColumns blocks.

module aes_inv_sub_bytes (
  input  logic [127:0] block,
  output logic [127:0] new_block
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Undo the affine transform, then invert in the field
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  always_comb begin
    new_block = '0;
    for (int k = 0; k < 16; k++) new_block[8*k +: 8] = inv_sbox(block[8*k +: 8]);
  end
endmodule

module aes_inv_mix_columns (
  input  logic [127:0] block,
  output logic [127:0] new_block
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    new_block = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) begin
        a[j]  = block[32*c + 8*j +: 8];
        x2[j] = xtime(a[j]);
        x4[j] = xtime(x2[j]);
        x8[j] = xtime(x4[j]);
        m9[j] = x8[j] ^ a[j];
        mb[j] = x8[j] ^ x2[j] ^ a[j];
        md[j] = x8[j] ^ x4[j] ^ a[j];
        me[j] = x8[j] ^ x4[j] ^ x2[j];
      end
      new_block[32*c +  0 +: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      new_block[32*c +  8 +: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      new_block[32*c + 16 +: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      new_block[32*c + 24 +: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
  end
endmodule

module aes_dec_core #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);
  localparam int unsigned BLK_W = 128;
  localparam int unsigned RND_W = 4;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [BLK_W-1:0] state_q, state_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [RND_W-1:0] key_idx_q, key_idx_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [BLK_W-1:0] shifted, subbed, keyed, mixed;

  // Inverse ShiftRows: row r rotates right by r columns
  always_comb begin
    shifted = '0;
    for (int k = 0; k < 16; k++) begin
      shifted[8*k +: 8] = state_q[8*((k - 4*(k % 4) + 16) % 16) +: 8];
    end
  end

  aes_inv_sub_bytes u_inv_sub_bytes (.block(shifted), .new_block(subbed));

  assign keyed = subbed ^ round_key;

  aes_inv_mix_columns u_inv_mix_columns (.block(keyed), .new_block(mixed));

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = in_block ^ round_key;
          rnd_d   = RND_W'(NR - 1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (rnd_q != '0) begin
          state_d = mixed;
          rnd_d   = rnd_q - RND_W'(1);
        end else begin
          state_d = keyed;
          fsm_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state implies
    in_ready_d  = (fsm_d == IDLE);
    busy_d      = (fsm_d == ROUND);
    out_valid_d = (fsm_d == DONE);
    unique case (fsm_d)
      ROUND:   key_idx_d = rnd_d;
      DONE:    key_idx_d = '0;
      default: key_idx_d = RND_W'(NR);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rnd_q       <= '0;
      key_idx_q   <= RND_W'(NR);
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      key_idx_q   <= key_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign key_idx   = key_idx_q;
  assign out_block = state_q;
endmodule

// File: doc/aes_dec_core.md
Name: aes_dec_core

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 InvCipher). Decrypts one 128-bit block with one round per clock.
- Sits opposite the encrypt datapath in the core.
- Round keys come from an external key-schedule store, which this block addresses by round index.
- Inverse ShiftRows is implemented inline. InvSubBytes and InvMixColumns instantiate the common aes_inv_sub_bytes and aes_inv_mix_columns modules (block/new_block ports).

Parameters:
- NR, 10, number of rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- clk  input  1  clock, all flops on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ciphertext block valid
- in_ready  output  1  block can accept a ciphertext
- in_block  input  `AES_BLOCK_SIZE  ciphertext
- key_idx  output  4  round-key index requested (0..10)
- round_key  input  `AES_BLOCK_SIZE  round key for key_idx, valid combinationally in the same cycle
- out_valid  output  1  plaintext valid
- out_ready  input  1  downstream accepts plaintext
- out_block  output  `AES_BLOCK_SIZE  plaintext
- busy  output  1  high in ROUND state

Behaviour:
- Byte order: state byte k (FIPS s_k, column-major) = block[8*k +: 8]. Byte 0 is the LSB byte.
- InvShiftRows: out[k] = in[(k - 4*(k%4)) mod 16]. Examples:
  - out[1]=in[13], out[2]=in[10], out[3]=in[7]
  - out[5]=in[1], out[6]=in[14], out[7]=in[11]
  - out[0]=in[0], out[4]=in[4], out[8]=in[8], out[12]=in[12]
- Registers: state (128b), rnd (4b), fsm. Reset (async, rst_n=0) values:
  - fsm=IDLE, rnd=0, state=0
  - in_ready=0 during reset, then 1 in IDLE
  - out_valid=0, busy=0, out_block=0, key_idx=NR
- IDLE:
  - in_ready=1, key_idx=10.
  - On in_valid&&in_ready: state<=in_block^round_key, rnd<=9, go ROUND.
- ROUND:
  - in_ready=0, busy=1, key_idx=rnd.
  - rnd>=1: state<=InvMixColumns(InvSubBytes(InvShiftRows(state))^round_key), rnd<=rnd-1.
  - rnd==0: state<=InvSubBytes(InvShiftRows(state))^round_key, go DONE.
- DONE:
  - out_valid=1, out_block=state, in_ready=0, key_idx=0.
  - On out_ready: go IDLE. in_ready rises the following cycle; no same-cycle accept in DONE.
- Latency:
  - Accept at edge T. Ten ROUND edges follow (T+1..T+10).
  - out_valid=1 from edge T+10. Acceptance-to-out_valid = 10 cycles.
  - Minimum throughput 1 block per 12 cycles with out_ready held high.
- Backpressure: out_ready=0 holds DONE indefinitely with out_block stable. in_valid is ignored outside IDLE.
- out_block is driven from state only. Intermediate round values are visible only while out_valid=0.
- key_idx is a registered-state function (fsm, rnd) with no combinational path from inputs.
- Reset asserted mid-operation: the immediate return to IDLE values discards any in-flight block. No output is produced for it.
- in_block/round_key X while not sampled must not propagate into out_block once out_valid=1.

Test Plan:
- FIPS-197 C.1 vector, key 000102..0f, bench key-schedule model driving round_key from key_idx: in_block=128'h5ac5b47080b7cdd830047b6ad8e0c469 (ct 69c4e0d8...c55a) -> out_block=128'hffeeddccbbaa99887766554433221100 (pt 00112233...eeff), out_valid exactly 10 cycles after acceptance.
- key_idx trace for one block: 10 in IDLE, then 9,8,...,0 on consecutive cycles, then 0 in DONE.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_valid stays 1, out_block unchanged, in_ready=0, in_valid pulses ignored. Release -> one transfer, in_ready=1 next cycle.
- Back-to-back: 3 random blocks, in_valid held high and out_ready=1 -> each output matches reference decrypt, in order, 12-cycle spacing.
- Reset mid-decrypt: drop rst_n at round 5 -> out_valid=0, busy=0, in_ready=1 after release. The next block decrypts correctly.
- InvShiftRows unit check: bypass with zero key and identity-like stimulus byte k=k is not possible through S-box. Check instead that round-0 output for state=0, round_key=0 equals 128'h52 repeated (InvSbox(0)=0x52 in all bytes).
